// File: rtl/shift_add_mult_pkg.sv
// Shared types and sizing helpers for the shift-and-add multiplier.
package shift_add_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Iterations needed to consume every multiplier bit.
    function automatic int num_iter(input int width, input int bpc);
        return width / bpc;
    endfunction

    function automatic int cnt_width(input int width, input int bpc);
        return $clog2(num_iter(width, bpc) + 1);
    endfunction

endpackage

// File: rtl/partial_product_gen.sv
// Combinational partial product: sum of mcand shifted by each set bit of k.
module partial_product_gen #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [2*WIDTH-1:0]        mcand,
    input  logic [BITS_PER_CYCLE-1:0] k,
    output logic [2*WIDTH-1:0]        pp
);

    logic [BITS_PER_CYCLE-1:0][2*WIDTH-1:0] terms;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_term
        assign terms[i] = k[i] ? (mcand << i) : '0;
    end

    always_comb begin
        pp = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) pp = pp + terms[i];
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier, BITS_PER_CYCLE multiplier bits per clock.
// Optional: SHIFT_ADD_MULT_EARLY_TERM_EN finishes as soon as the remaining multiplier is zero.
module shift_add_multiplier
    import shift_add_mult_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int N  = num_iter(WIDTH, BITS_PER_CYCLE);
    localparam int CW = cnt_width(WIDTH, BITS_PER_CYCLE);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((WIDTH < 2) || (WIDTH % BITS_PER_CYCLE != 0) ||
        (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4)) begin : g_bad_cfg
        $fatal(1, "shift_add_multiplier: illegal WIDTH/BITS_PER_CYCLE combination");
    end

    state_t               state;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   pp;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [WIDTH-1:0]     mplr;
    logic [CW-1:0]        cnt;
    logic                 skip;
    logic                 fin;

    partial_product_gen #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_ppgen (
        .mcand (mcand),
        .k     (mplr[BITS_PER_CYCLE-1:0]),
        .pp    (pp)
    );

`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
    assign skip = (mplr == '0);
`else
    assign skip = 1'b0;
`endif

    // Carry out of 2*WIDTH cannot happen for unsigned operands, so it is dropped.
    assign acc_sum = skip ? acc : (acc + pp);
    assign fin     = skip || (cnt == LAST);

    assign busy = (state == ST_BUSY);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            mcand   <= '0;
            mplr    <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state <= ST_BUSY;
                        mcand <= {{WIDTH{1'b0}}, a};
                        mplr  <= b;
                        acc   <= '0;
                        cnt   <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    acc   <= acc_sum;
                    mcand <= mcand << BITS_PER_CYCLE;
                    mplr  <= mplr >> BITS_PER_CYCLE;
                    cnt   <= cnt + CW'(1);
                    // Product is loaded on the final iteration so it is valid with done.
                    if (fin) begin
                        state   <= ST_DONE;
                        product <= acc_sum;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
